// File: rtl/nios_cpu_debug_pkg.sv
// Shared constants for the OCI debug RAM arbiter: jdo field positions,
// buffered JTAG op encoding, grant encoding and FSM state codes.
package nios_cpu_debug_pkg;

    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 17;

    localparam logic JOP_RD = 1'b0;
    localparam logic JOP_WR = 1'b1;

    localparam logic GRANT_AV = 1'b0;
    localparam logic GRANT_JT = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_AV_WR     = 3'd1;
    localparam state_t ST_AV_RD     = 3'd2;
    localparam state_t ST_AV_RDDATA = 3'd3;
    localparam state_t ST_JT_WR     = 3'd4;
    localparam state_t ST_JT_RD     = 3'd5;
    localparam state_t ST_JT_RDDATA = 3'd6;

endpackage

// File: rtl/nios_cpu_debug_jtag_opbuf.sv
// JTAG side of the arbiter: resolves coincident action pulses, keeps the
// auto-incrementing JTAG address counter and holds one buffered access.
// Pulses cannot be stalled, so anything that does not fit is dropped and
// flagged in the sticky overrun bit.
module nios_cpu_debug_jtag_opbuf
    import nios_cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              consume,
    output logic              jpend,
    output logic              op,
    output logic [ADDR_W-1:0] op_addr,
    output logic [31:0]       op_wdata,
    output logic              jtag_overrun
);

    logic [ADDR_W-1:0] jaddr;
    logic              access_req;
    logic              can_accept;
    logic              accept;
    logic              drop;
    logic              unused_jdo;

    // Only the write-data and address fields of jdo are meaningful here.
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // Pulse priority a > b > no_action_a; the buffer slot frees up in the
    // cycle the FSM consumes it, so a pulse landing then is still accepted.
    always_comb begin
        access_req = !take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a);
        can_accept = !jpend || consume;
        accept     = access_req && can_accept;
        drop       = (take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a))
                   || (take_action_ocimem_b && take_no_action_ocimem_a)
                   || (access_req && !can_accept);
    end

    // Address counter, single-entry op buffer and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jaddr        <= '0;
            jpend        <= 1'b0;
            op           <= JOP_RD;
            op_addr      <= '0;
            op_wdata     <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (take_action_ocimem_a) begin
                jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
            end else if (accept) begin
                jaddr <= jaddr + ADDR_W'(1);
            end

            if (accept) begin
                jpend    <= 1'b1;
                op       <= take_action_ocimem_b ? JOP_WR : JOP_RD;
                op_addr  <= jaddr;
                op_wdata <= jdo[JDO_WDATA_LSB +: 32];
            end else if (consume) begin
                jpend <= 1'b0;
            end

            // A drop in the same cycle as an address load still counts.
            if (drop) begin
                jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
                jtag_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nios_cpu_debug_mem_arbiter.sv
// Shares the single-port OCI debug RAM (read latency 1) between buffered
// JTAG debug accesses and the Avalon-MM debug slave. All RAM strobes are
// registered; ties between requesters alternate via last_grant.
//
// Avalon handshake: the master holds av_read/av_write and its address/data
// stable while av_waitrequest=1; the transfer completes in the single cycle
// av_waitrequest=0 (AV_WR for writes, AV_RDDATA with av_readdata valid).
module nios_cpu_debug_mem_arbiter
    import nios_cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              mon_rd_valid,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wrdata,
    output logic [3:0]        ram_byteenable,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rddata,
    output logic [2:0]        fsm_state
);

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] mon_reg;
    logic              jpend;
    logic              op;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              consume;
    logic              av_req;
    logic              grant_jt;
    logic              grant_av;

    nios_cpu_debug_jtag_opbuf #(
        .ADDR_W (ADDR_W)
    ) u_opbuf (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .consume                 (consume),
        .jpend                   (jpend),
        .op                      (op),
        .op_addr                 (op_addr),
        .op_wdata                (op_wdata),
        .jtag_overrun            (jtag_overrun)
    );

    assign fsm_state = state;

    // Arbitration in IDLE: a lone requester wins, a tie goes to the side
    // that did not win last time.
    always_comb begin
        av_req   = av_read || av_write;
        grant_jt = jpend && (!av_req || (last_grant == GRANT_AV));
        grant_av = av_req && !grant_jt;
    end

    // Completion outputs; read data is bypassed straight from the RAM so it
    // is valid in the same cycle as the completion indication.
    always_comb begin
        consume        = (state == ST_JT_WR) || (state == ST_JT_RDDATA);
        av_waitrequest = !((state == ST_AV_WR) || (state == ST_AV_RDDATA));
        av_readdata    = (state == ST_AV_RDDATA) ? ram_rddata : '0;
        mon_rd_valid   = (state == ST_JT_RDDATA);
        MonDReg        = mon_rd_valid ? ram_rddata : mon_reg;
    end

    // FSM with registered RAM command outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            last_grant     <= GRANT_AV;
            ram_addr       <= '0;
            ram_wrdata     <= '0;
            ram_byteenable <= '0;
            ram_wr         <= 1'b0;
            ram_rd         <= 1'b0;
            mon_reg        <= '0;
        end else begin
            ram_wr <= 1'b0;
            ram_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_jt) begin
                        last_grant <= GRANT_JT;
                        ram_addr   <= op_addr;
                        if (op == JOP_WR) begin
                            state          <= ST_JT_WR;
                            ram_wr         <= 1'b1;
                            ram_wrdata     <= op_wdata;
                            ram_byteenable <= 4'hF;
                        end else begin
                            state  <= ST_JT_RD;
                            ram_rd <= 1'b1;
                        end
                    end else if (grant_av) begin
                        last_grant     <= GRANT_AV;
                        ram_addr       <= av_address;
                        ram_byteenable <= av_byteenable;
                        if (av_write) begin
                            state      <= ST_AV_WR;
                            ram_wr     <= 1'b1;
                            ram_wrdata <= av_writedata;
                        end else begin
                            state  <= ST_AV_RD;
                            ram_rd <= 1'b1;
                        end
                    end
                end
                ST_AV_RD: state <= ST_AV_RDDATA;
                ST_JT_RD: state <= ST_JT_RDDATA;
                ST_JT_RDDATA: begin
                    mon_reg <= ram_rddata;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
